// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared processor types and constants for the memory-access stage
package mem_access_unit_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mau_state_e;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WAIT_CNT_W      = 4;

    // Memory operations are doubleword-granular; any low address bit set is an alignment fault.
    function automatic logic dword_aligned(input logic [2:0] addr_lsb);
        return addr_lsb == 3'd0;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-access pipeline stage with request/ack data-memory port and timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         Branch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,
    input  logic [N-1:0] PCBranch_E,
    output logic         stall,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         valid_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic         mem_error
);

    mau_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [N-1:0]            addr_q, wdata_q, pcb_q;
    logic                    we_q, taken_q;
    logic                    valid_m_q, pcsrc_m_q, err_q;
    logic [N-1:0]            rdata_m_q, alu_m_q, pcb_m_q;

    logic accept, is_single_mem, bad_op, go_mem, timeout_hit, done;

    always_comb begin
        accept        = (state_q == IDLE) && valid_E;
        is_single_mem = MemRead_E ^ MemWrite_E;
        bad_op        = (MemRead_E && MemWrite_E) ||
                        ((MemRead_E || MemWrite_E) && !dword_aligned(aluResult_E[2:0]));
        go_mem        = accept && is_single_mem && !bad_op;
        // An ack in the final wait cycle takes priority over the timeout.
        timeout_hit   = (state_q == ACCESS) && !dm_ack && (cnt_q == WAIT_CNT_W'(TIMEOUT - 1));
        done          = (state_q == ACCESS) && (dm_ack || timeout_hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_mem) state_d = ACCESS;
            ACCESS:  if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall  = (state_q == ACCESS);
        dm_req = (state_q == ACCESS);
        dm_we  = (state_q == ACCESS) && we_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pcb_q     <= '0;
            we_q      <= 1'b0;
            taken_q   <= 1'b0;
            valid_m_q <= 1'b0;
            pcsrc_m_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_m_q <= '0;
            alu_m_q   <= '0;
            pcb_m_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= aluResult_E;
                wdata_q <= writeData_E;
                pcb_q   <= PCBranch_E;
                we_q    <= MemWrite_E;
                taken_q <= Branch_E && zero_E;
            end

            if (go_mem)
                cnt_q <= '0;
            else if ((state_q == ACCESS) && !dm_ack)
                cnt_q <= cnt_q + 1'b1;

            valid_m_q <= (accept && !go_mem) || done;

            if (accept && !go_mem) begin
                rdata_m_q <= '0;
                alu_m_q   <= aluResult_E;
                pcb_m_q   <= PCBranch_E;
                pcsrc_m_q <= Branch_E && zero_E;
            end else if (done) begin
                rdata_m_q <= (dm_ack && !we_q) ? dm_rdata : '0;
                alu_m_q   <= addr_q;
                pcb_m_q   <= pcb_q;
                pcsrc_m_q <= taken_q;
            end

            if ((accept && bad_op) || timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;
    assign valid_M     = valid_m_q;
    assign readData_M  = rdata_m_q;
    assign aluResult_M = alu_m_q;
    assign PCBranch_M  = pcb_m_q;
    assign PCSrc_M     = pcsrc_m_q && valid_m_q;
    assign mem_error   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int N       = 64;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E, MemRead_E, MemWrite_E, Branch_E, zero_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
    logic         stall, dm_req, dm_we, dm_ack;
    logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
    logic         valid_M, PCSrc_M, mem_error;
    logic [N-1:0] readData_M, aluResult_M, PCBranch_M;

    int   errors = 0;
    int   checks = 0;
    logic exp_err = 1'b0;

    mem_access_unit #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E),
        .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .Branch_E(Branch_E),
        .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
        .PCBranch_E(PCBranch_E), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .valid_M(valid_M), .readData_M(readData_M), .aluResult_M(aluResult_M),
        .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic scramble_e();
        MemRead_E   = 1'($urandom_range(0, 1));
        MemWrite_E  = 1'($urandom_range(0, 1));
        Branch_E    = 1'($urandom_range(0, 1));
        zero_E      = 1'($urandom_range(0, 1));
        aluResult_E = rand64();
        writeData_E = rand64();
        PCBranch_E  = rand64();
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    // ack_delay = idle cycles of dm_req before dm_ack; >= TIMEOUT means never acknowledged.
    task automatic run_op(input logic mr, input logic mw, input logic br, input logic z,
                          input logic [N-1:0] alu, input logic [N-1:0] wd, input logic [N-1:0] pcb,
                          input int ack_delay, input logic [N-1:0] rdata);
        logic bad, is_mem, acked;
        int   wait_cycles;
        bad    = (mr && mw) || ((mr || mw) && (alu[2:0] != 3'd0));
        is_mem = (mr || mw) && !bad;
        acked  = 1'b0;
        check_eq("idle_stall", stall, 1'b0);
        MemRead_E = mr; MemWrite_E = mw; Branch_E = br; zero_E = z;
        aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
        valid_E = 1'b1;
        @(negedge clk);
        valid_E = 1'b0;
        scramble_e();
        if (is_mem) begin
            acked       = (ack_delay < TIMEOUT);
            wait_cycles = acked ? ack_delay + 1 : TIMEOUT;
            for (int k = 1; k <= wait_cycles; k++) begin
                check_eq("acc_req", dm_req, 1'b1);
                check_eq("acc_stall", stall, 1'b1);
                check_eq("acc_addr", dm_addr, alu);
                check_eq("acc_we", dm_we, mw);
                if (mw) check_eq("acc_wdata", dm_wdata, wd);
                check_eq("acc_valid", valid_M, 1'b0);
                if (k == wait_cycles && acked) begin
                    dm_ack   = 1'b1;
                    dm_rdata = rdata;
                end
                @(negedge clk);
                dm_ack   = 1'b0;
                dm_rdata = rand64();
            end
            if (!acked) exp_err = 1'b1;
        end else if (bad) begin
            exp_err = 1'b1;
        end
        check_eq("ret_valid", valid_M, 1'b1);
        check_eq("ret_req", dm_req, 1'b0);
        check_eq("ret_stall", stall, 1'b0);
        check_eq("ret_alu", aluResult_M, alu);
        check_eq("ret_pcb", PCBranch_M, pcb);
        check_eq("ret_pcsrc", PCSrc_M, br && z);
        check_eq("ret_rdata", readData_M, (is_mem && acked && mr) ? rdata : '0);
        check_eq("ret_err", mem_error, exp_err);
        @(negedge clk);
        check_eq("pulse_valid", valid_M, 1'b0);
        check_eq("pulse_pcsrc", PCSrc_M, 1'b0);
        dm_ack   = 1'($urandom_range(0, 1));
        dm_rdata = rand64();
        @(negedge clk);
        dm_ack = 1'b0;
        check_eq("idle_ack_valid", valid_M, 1'b0);
        check_eq("idle_ack_req", dm_req, 1'b0);
    endtask

    initial begin
        reset = 1'b0; valid_E = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        MemRead_E = 1'b0; MemWrite_E = 1'b0; Branch_E = 1'b0; zero_E = 1'b0;
        aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
        #3;
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_req", dm_req, 1'b0);
        check_eq("rst_valid", valid_M, 1'b0);
        check_eq("rst_err", mem_error, 1'b0);
        check_eq("rst_addr", dm_addr, '0);
        check_eq("rst_rdata", readData_M, '0);
        @(negedge clk);
        reset = 1'b1;

        run_op(0, 0, 0, 0, 64'h2A, 64'h0, 64'h0, 0, '0);
        run_op(1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 3, 64'hDEADBEEF);
        run_op(0, 1, 0, 0, 64'h08, 64'h55, 64'h0, 0, '0);
        run_op(0, 0, 1, 1, 64'h7, 64'h0, 64'h40, 0, '0);
        run_op(1, 0, 0, 0, 64'h208, 64'h0, 64'h0, TIMEOUT - 1, 64'h1122334455667788);
        run_op(1, 0, 0, 0, 64'h300, 64'h0, 64'h0, 40, 64'hFFFF);
        run_op(0, 0, 0, 0, 64'h99, 64'h0, 64'h0, 0, '0);
        run_op(1, 0, 1, 1, 64'h104, 64'h0, 64'h80, 0, '0);
        run_op(1, 1, 0, 0, 64'h110, 64'h3, 64'h0, 0, '0);

        // valid_E held across a stall is taken in the first idle cycle
        MemRead_E = 1'b1; MemWrite_E = 1'b0; Branch_E = 1'b0; zero_E = 1'b0;
        aluResult_E = 64'h200; PCBranch_E = 64'h0; valid_E = 1'b1;
        @(negedge clk);
        MemRead_E = 1'b0; aluResult_E = 64'h77; PCBranch_E = 64'h5;
        check_eq("hold_stall", stall, 1'b1);
        @(negedge clk);
        check_eq("hold_addr", dm_addr, 64'h200);
        dm_ack = 1'b1; dm_rdata = 64'h1234;
        @(negedge clk);
        dm_ack = 1'b0;
        check_eq("hold_ret_valid", valid_M, 1'b1);
        check_eq("hold_ret_rdata", readData_M, 64'h1234);
        check_eq("hold_ret_alu", aluResult_M, 64'h200);
        @(negedge clk);
        valid_E = 1'b0;
        check_eq("held_valid", valid_M, 1'b1);
        check_eq("held_alu", aluResult_M, 64'h77);
        check_eq("held_pcb", PCBranch_M, 64'h5);
        check_eq("held_req", dm_req, 1'b0);
        @(negedge clk);

        // reset during the second access cycle aborts the request
        MemRead_E = 1'b1; aluResult_E = 64'h300; valid_E = 1'b1;
        @(negedge clk);
        valid_E = 1'b0;
        @(negedge clk);
        check_eq("mid_req_before", dm_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        exp_err = 1'b0;
        check_eq("mid_req", dm_req, 1'b0);
        check_eq("mid_stall", stall, 1'b0);
        check_eq("mid_valid", valid_M, 1'b0);
        check_eq("mid_err", mem_error, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        dm_ack = 1'b1; dm_rdata = 64'hBAD;
        @(negedge clk);
        dm_ack = 1'b0;
        check_eq("late_ack_valid", valid_M, 1'b0);
        check_eq("late_ack_req", dm_req, 1'b0);
        check_eq("late_ack_stall", stall, 1'b0);
        run_op(0, 0, 0, 0, 64'h31, 64'h0, 64'h0, 0, '0);

        for (int t = 0; t < 60; t++) begin
            int unsigned op;
            logic [N-1:0] a;
            op = $urandom_range(0, 4);
            a  = rand64();
            case (op)
                0: run_op(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rand64(), rand64(), 0, '0);
                1: begin a[2:0] = 3'd0; run_op(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rand64(), rand64(), int'($urandom_range(0, 17)), rand64()); end
                2: begin a[2:0] = 3'd0; run_op(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rand64(), rand64(), int'($urandom_range(0, 17)), rand64()); end
                3: run_op(1, 1, 0, 0, a, rand64(), rand64(), 0, '0);
                default: begin a[2:0] = 3'($urandom_range(1, 7)); run_op(1'($urandom_range(0, 1)), 1'b1, 0, 0, a, rand64(), rand64(), 0, '0); end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
